// File: rtl/cpu_sram_arbiter.sv
// rtl/cpu_sram_arbiter.sv - 2:1 inst/data arbiter onto one SRAM-like slave with in-order response steering
// CPU_ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed data-over-inst priority.
module cpu_sram_arbiter #(
   parameter int OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_req,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        slv_req,
   output logic [3:0]  slv_wstrb,
   output logic [31:0] slv_addr,
   output logic [31:0] slv_wdata,
   input  logic        slv_addr_ok,
   input  logic        slv_data_ok,
   input  logic [31:0] slv_rdata
);

   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING + 1);

   logic [OUTSTANDING-1:0] fifo_id;
   logic [PW-1:0]          head;
   logic [PW-1:0]          tail;
   logic [CW-1:0]          count;
   logic                   lock_vld;
   logic                   lock_id;
`ifdef CPU_ARB_ROUND_ROBIN_EN
   logic                   rr_ptr;
`endif

   logic grant_vld;
   logic grant_id;
   logic grant_req;
   logic fifo_full;
   logic fifo_empty;
   logic accept;
   logic resp_fire;
   logic head_id;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   // A presented-but-unaccepted request owns the port until the slave takes it.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (lock_vld) begin
         grant_vld = 1'b1;
         grant_id  = lock_id;
      end else if (inst_req || data_req) begin
         grant_vld = 1'b1;
`ifdef CPU_ARB_ROUND_ROBIN_EN
         grant_id  = (inst_req && data_req) ? rr_ptr : data_req;
`else
         grant_id  = data_req;
`endif
      end
   end

   assign fifo_full  = (count == CW'(OUTSTANDING));
   assign fifo_empty = (count == '0);
   assign grant_req  = grant_id ? data_req : inst_req;

   assign slv_req   = grant_vld && grant_req && !fifo_full;
   assign slv_wstrb = !grant_vld ? 4'h0  : (grant_id ? data_wstrb : inst_wstrb);
   assign slv_addr  = !grant_vld ? 32'h0 : (grant_id ? data_addr  : inst_addr);
   assign slv_wdata = !grant_vld ? 32'h0 : (grant_id ? data_wdata : inst_wdata);

   assign accept       = slv_req && slv_addr_ok;
   assign inst_addr_ok = accept && !grant_id;
   assign data_addr_ok = accept &&  grant_id;

   // Responses with nothing outstanding are dropped rather than misrouted.
   assign head_id      = fifo_id[head];
   assign resp_fire    = slv_data_ok && !fifo_empty;
   assign inst_data_ok = resp_fire && !head_id;
   assign data_data_ok = resp_fire &&  head_id;
   assign inst_rdata   = inst_data_ok ? slv_rdata : 32'h0;
   assign data_rdata   = data_data_ok ? slv_rdata : 32'h0;

   always_ff @(posedge clk) begin
      if (accept)
         fifo_id[tail] <= grant_id;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         lock_vld <= 1'b0;
         lock_id  <= 1'b0;
`ifdef CPU_ARB_ROUND_ROBIN_EN
         rr_ptr   <= 1'b0;
`endif
      end else begin
         if (accept)
            tail <= ptr_next(tail);
         if (resp_fire)
            head <= ptr_next(head);
         case ({accept, resp_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (accept) begin
            lock_vld <= 1'b0;
         end else if (slv_req) begin
            lock_vld <= 1'b1;
            lock_id  <= grant_id;
         end
`ifdef CPU_ARB_ROUND_ROBIN_EN
         if (accept)
            rr_ptr <= ~grant_id;
`endif
      end
   end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// tb/tb_cpu_sram_arbiter.sv - directed scoreboard bench for cpu_sram_arbiter
// Expected accepts/responses are queued by stimulus and popped by a negedge monitor.
module tb_cpu_sram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, data_req;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        slv_req, slv_addr_ok, slv_data_ok;
   logic [3:0]  slv_wstrb;
   logic [31:0] slv_addr, slv_wdata, slv_rdata;

   typedef struct packed {
      logic        id;
      logic [31:0] val;
   } exp_t;

   exp_t exp_acc[$];
   exp_t exp_rsp[$];
   exp_t e_acc, e_rsp;
   int   n_cmp = 0;
   int   n_err = 0;
   logic first;

   cpu_sram_arbiter #(.OUTSTANDING(2)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .slv_req(slv_req), .slv_wstrb(slv_wstrb), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
      .slv_addr_ok(slv_addr_ok), .slv_data_ok(slv_data_ok), .slv_rdata(slv_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1);
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (inst_addr_ok || data_addr_ok) begin
            n_cmp++;
            if (exp_acc.size() == 0) begin
               n_err++;
               $display("FAIL accept_unexpected: got inst_ok=%b data_ok=%b addr=%h required no accept",
                        inst_addr_ok, data_addr_ok, slv_addr);
            end else begin
               e_acc = exp_acc.pop_front();
               if ({data_addr_ok, inst_addr_ok, slv_addr} !== {e_acc.id, !e_acc.id, e_acc.val}) begin
                  n_err++;
                  $display("FAIL accept: got data_ok=%b inst_ok=%b addr=%h required id=%b addr=%h",
                           data_addr_ok, inst_addr_ok, slv_addr, e_acc.id, e_acc.val);
               end
            end
         end
         if (inst_data_ok || data_data_ok) begin
            n_cmp++;
            if (exp_rsp.size() == 0) begin
               n_err++;
               $display("FAIL response_unexpected: got inst_ok=%b data_ok=%b required no response",
                        inst_data_ok, data_data_ok);
            end else begin
               e_rsp = exp_rsp.pop_front();
               if ({data_data_ok, inst_data_ok, inst_rdata, data_rdata} !==
                   {e_rsp.id, !e_rsp.id, (e_rsp.id ? 32'h0 : e_rsp.val), (e_rsp.id ? e_rsp.val : 32'h0)}) begin
                  n_err++;
                  $display("FAIL response: got data_ok=%b inst_ok=%b inst_rdata=%h data_rdata=%h required id=%b rdata=%h",
                           data_data_ok, inst_data_ok, inst_rdata, data_rdata, e_rsp.id, e_rsp.val);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      inst_req = 1'b0; inst_wstrb = 4'h0; inst_addr = 32'h0; inst_wdata = 32'h0;
      data_req = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
      slv_addr_ok = 1'b0; slv_data_ok = 1'b0; slv_rdata = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {slv_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, slv_wstrb}, 64'h0);
      chk({tag, "_addr"}, slv_addr, 64'h0);
      chk({tag, "_wdata"}, slv_wdata, 64'h0);
      chk({tag, "_rdata"}, {inst_rdata, data_rdata}, 64'h0);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      smp();
      chk_all_zero("reset");

      // Single fetch, response two cycles after accept
      tick();
      inst_req = 1'b1; inst_addr = 32'h1C000000; slv_addr_ok = 1'b1;
      exp_acc.push_back({1'b0, 32'h1C000000});
      smp();
      chk("t1_slv_req", slv_req, 1);
      tick();
      inst_req = 1'b0; slv_addr_ok = 1'b0;
      tick();
      slv_data_ok = 1'b1; slv_rdata = 32'h02800C0C;
      exp_rsp.push_back({1'b0, 32'h02800C0C});
      smp();
      chk("t1_data_data_ok", data_data_ok, 0);
      tick();
      slv_data_ok = 1'b0; slv_rdata = 32'h0;

      // Simultaneous requests
      do_reset();
`ifdef CPU_ARB_ROUND_ROBIN_EN
      first = 1'b0;
`else
      first = 1'b1;
`endif
      inst_req = 1'b1; inst_addr = 32'h1C000010;
      data_req = 1'b1; data_addr = 32'h00001000;
      slv_addr_ok = 1'b1;
      exp_acc.push_back({first, first ? 32'h00001000 : 32'h1C000010});
      smp();
      chk("t2_first_addr", slv_addr, first ? 64'h00001000 : 64'h1C000010);
      tick();
      if (first) data_req = 1'b0;
      else inst_req = 1'b0;
      exp_acc.push_back({!first, first ? 32'h1C000010 : 32'h00001000});
      tick();
      inst_req = 1'b0; data_req = 1'b0; slv_addr_ok = 1'b0;
      slv_data_ok = 1'b1; slv_rdata = 32'h11111111;
      exp_rsp.push_back({first, 32'h11111111});
      tick();
      slv_rdata = 32'h22222222;
      exp_rsp.push_back({!first, 32'h22222222});
      tick();
      slv_data_ok = 1'b0; slv_rdata = 32'h0;

      // Lock: stalled fetch is not preempted by a later store
      do_reset();
      inst_req = 1'b1; inst_addr = 32'h1C000020;
      smp();
      chk("t3_c0", {slv_req, slv_addr}, {1'b1, 32'h1C000020});
      tick();
      data_req = 1'b1; data_addr = 32'h00002000; data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF;
      smp();
      chk("t3_c1", {slv_req, slv_addr}, {1'b1, 32'h1C000020});
      tick();
      smp();
      chk("t3_c2", {slv_req, slv_addr, slv_wstrb}, {1'b1, 32'h1C000020, 4'h0});
      tick();
      slv_addr_ok = 1'b1;
      exp_acc.push_back({1'b0, 32'h1C000020});
      tick();
      inst_req = 1'b0;
      exp_acc.push_back({1'b1, 32'h00002000});
      smp();
      chk("t3_store", {slv_wstrb, slv_wdata}, {4'hF, 32'hDEADBEEF});
      tick();
      data_req = 1'b0; data_wstrb = 4'h0; slv_addr_ok = 1'b0;
      slv_data_ok = 1'b1; slv_rdata = 32'h33333333;
      exp_rsp.push_back({1'b0, 32'h33333333});
      tick();
      slv_rdata = 32'h0;
      exp_rsp.push_back({1'b1, 32'h0});
      tick();
      slv_data_ok = 1'b0;

      // Full owner FIFO blocks issue; a pop re-enables it only the next cycle
      do_reset();
      inst_req = 1'b1; inst_addr = 32'h00000100; slv_addr_ok = 1'b1;
      exp_acc.push_back({1'b0, 32'h00000100});
      tick();
      inst_addr = 32'h00000104;
      exp_acc.push_back({1'b0, 32'h00000104});
      tick();
      inst_addr = 32'h00000108;
      smp();
      chk("t4_full_req", slv_req, 0);
      tick();
      slv_data_ok = 1'b1; slv_rdata = 32'h44444444;
      exp_rsp.push_back({1'b0, 32'h44444444});
      smp();
      chk("t4_pop_no_push", slv_req, 0);
      tick();
      slv_data_ok = 1'b0;
      exp_acc.push_back({1'b0, 32'h00000108});
      smp();
      chk("t4_reissue", slv_req, 1);
      tick();
      inst_req = 1'b0; slv_addr_ok = 1'b0;
      slv_data_ok = 1'b1; slv_rdata = 32'h55555555;
      exp_rsp.push_back({1'b0, 32'h55555555});
      tick();
      slv_rdata = 32'h66666666;
      exp_rsp.push_back({1'b0, 32'h66666666});
      tick();
      slv_data_ok = 1'b0; slv_rdata = 32'h0;

      // Both masters requesting continuously with responses streaming back
      do_reset();
      inst_req = 1'b1; data_req = 1'b1; slv_addr_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         inst_addr = 32'h1C000100 + 32'(k);
         data_addr = 32'h00003000 + 32'(k);
`ifdef CPU_ARB_ROUND_ROBIN_EN
         exp_acc.push_back({k[0], k[0] ? data_addr : inst_addr});
         if (k > 0) exp_rsp.push_back({!k[0], 32'(k)});
`else
         exp_acc.push_back({1'b1, data_addr});
         if (k > 0) exp_rsp.push_back({1'b1, 32'(k)});
`endif
         slv_data_ok = (k > 0);
         slv_rdata = 32'(k);
         tick();
      end
      inst_req = 1'b0; data_req = 1'b0; slv_addr_ok = 1'b0;
      slv_data_ok = 1'b1; slv_rdata = 32'h4;
`ifdef CPU_ARB_ROUND_ROBIN_EN
      exp_rsp.push_back({1'b1, 32'h4});
`else
      exp_rsp.push_back({1'b1, 32'h4});
`endif
      tick();
      slv_data_ok = 1'b0; slv_rdata = 32'h0;

      // Reset with two outstanding, then a stray response
      do_reset();
      inst_req = 1'b1; inst_addr = 32'h00000400; slv_addr_ok = 1'b1;
      exp_acc.push_back({1'b0, 32'h00000400});
      tick();
      inst_addr = 32'h00000404;
      exp_acc.push_back({1'b0, 32'h00000404});
      tick();
      inst_req = 1'b0; slv_addr_ok = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      smp();
      chk_all_zero("t6_after_reset");
      tick();
      slv_data_ok = 1'b1; slv_rdata = 32'h77777777;
      smp();
      chk("t6_stray_ok", {inst_data_ok, data_data_ok}, 64'h0);
      chk("t6_stray_rdata", {inst_rdata, data_rdata}, 64'h0);
      tick();
      slv_data_ok = 1'b0; slv_rdata = 32'h0;
      inst_req = 1'b1; inst_addr = 32'h00000500; slv_addr_ok = 1'b1;
      exp_acc.push_back({1'b0, 32'h00000500});
      tick();
      inst_addr = 32'h00000504;
      exp_acc.push_back({1'b0, 32'h00000504});
      tick();
      inst_req = 1'b0; slv_addr_ok = 1'b0;
      slv_data_ok = 1'b1; slv_rdata = 32'h88888888;
      exp_rsp.push_back({1'b0, 32'h88888888});
      tick();
      slv_rdata = 32'h99999999;
      exp_rsp.push_back({1'b0, 32'h99999999});
      tick();
      slv_data_ok = 1'b0; slv_rdata = 32'h0;
      tick();

      chk("acc_queue_drained", 64'(exp_acc.size()), 64'h0);
      chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
